instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch initiator for the combinational instruction ROM. Owns the PC and drives ROM address each cycle.
//  Captures {pc, instr, fault} into a small FIFO and presents them to decode via valid/ready.
//  Handles redirects (branch/jump/trap) by flushing and restarting. Freezes on an unaligned-fetch fault.
//  Sits between the instruction ROM and the decode stage of the rv64i core.
// PARAMETERS
//  ADDR_WIDTH  64  PC / ROM address width
//  DATA_WIDTH  32  instruction width
//  RESET_PC    0   PC loaded on reset (ADDR_WIDTH bits)
//  FIFO_DEPTH  2   fetch buffer entries; power of two, >=2
// PORTS
//  clk_i            in   1           clock
//  rst_ni           in   1           synchronous reset, active-low
//  rom_addr_o       out  ADDR_WIDTH  address to ROM (= pc_q)
//  rom_data_i       in   DATA_WIDTH  ROM data, same-cycle combinational response
//  rom_illegal_i    in   1           ROM unaligned-access flag, same cycle
//  redirect_valid_i in   1           flush and restart fetch at redirect_pc_i
//  redirect_pc_i    in   ADDR_WIDTH  redirect target
//  instr_valid_o    out  1           FIFO head valid
//  instr_ready_i    in   1           decode accepts head
//  instr_o          out  DATA_WIDTH  head instruction (0 when fault entry)
//  instr_pc_o       out  ADDR_WIDTH  head PC
//  instr_fault_o    out  1           head entry is an unaligned-fetch fault
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): pc_q=RESET_PC, FIFO empty, state=RUN; instr_valid_o=0, instr_o=0,
//    instr_pc_o=0, instr_fault_o=0. Reset mid-stream discards all entries; first fetch on cycle after release.
//  - rom_addr_o = pc_q always (combinational from register), also in FAULT state.
//  - FSM: RUN, FAULT.
//    RUN: push = ~full_after_pop; full_after_pop = full & ~(instr_valid_o & instr_ready_i) (pop frees slot same cycle).
//      On push with rom_illegal_i=0: write {pc_q, rom_data_i, 0}; pc_q <= pc_q + 4 (wraps mod 2^ADDR_WIDTH).
//      On push with rom_illegal_i=1: write {pc_q, 0, 1}; pc_q held; -> FAULT.
//    FAULT: no pushes; FIFO keeps draining; stays until redirect.
//  - Redirect (any state) has top priority: FIFO flushed (count=0, pointers reset), same-cycle push and
//    pop suppressed, pc_q <= redirect_pc_i, state -> RUN. Head visible that cycle is NOT consumed even if ready=1.
//    First post-redirect instruction at instr_valid_o one cycle later (latency 1).
//  - Handshake: pop when instr_valid_o & instr_ready_i; instr_* stable while valid & ~ready.
//  - Simultaneous push and pop when full: allowed, count unchanged.
//  - Steady state with ready=1: one instruction per cycle; fetch-to-valid latency 1 cycle.
//  - Count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: adds outputs perf_fetched_o [63:0] (+1 per non-fault push) and
//    perf_stall_o [63:0] (+1 per RUN cycle with push blocked by full FIFO); both reset to 0, not cleared by redirect, wrap.
//  Undefined: ports and counters absent; other behaviour identical.
// TESTING
//  1 Reset, ROM words 0x13,0x93,0x113 at 0,4,8, ready=1 -> pc 0,4,8 at cycles 1,2,3 with matching instr, fault=0.
//  2 ready=0 for 5 cycles -> exactly FIFO_DEPTH entries held, rom_addr_o stalls at 8; head stable; resume in order.
//  3 Redirect to 0x40 while FIFO full -> valid=0 next cycle; then head pc=0x40; old entries never appear.
//  4 Redirect to 0x42 -> head pc=0x42, fault=1, instr=0; no further pushes; redirect to 0x44 resumes normal fetch.
//  5 Redirect to 2^64-4 -> pcs 0xFFFF_FFFF_FFFF_FFFC then 0x0 (wrap).
//  6 Deassert rst_ni mid-stream with 2 entries -> valid=0, next head pc=RESET_PC; with IFU_PERF_CNT_EN counters=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the combinational ROM and buffers {pc, instr, fault} for decode.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
//
// state   | meaning
// S_RUN   | fetching one word per cycle whenever the buffer has (or frees) a slot
// S_FAULT | unaligned fetch captured; no more fetches until a redirect
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  rom_illegal_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  instr_fault_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]           perf_fetched_o,
  output logic [63:0]           perf_stall_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_RUN,
    S_FAULT
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_buf_pc    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_buf_instr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_buf_fault;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic w_valid;
  logic w_full;
  logic w_pop_req;
  logic w_full_after_pop;
  logic w_pop;
  logic w_push;

  assign w_valid          = (r_count != '0);
  assign w_full           = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop_req        = w_valid & instr_ready_i;
  // A pop in the same cycle frees a slot, so a full buffer can still accept a fetch.
  assign w_full_after_pop = w_full & ~w_pop_req;
  assign w_pop            = w_pop_req & ~redirect_valid_i;
  assign w_push           = (r_state == S_RUN) & ~w_full_after_pop & ~redirect_valid_i;

  assign rom_addr_o    = r_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_buf_instr[r_rptr] : '0;
  assign instr_pc_o    = w_valid ? r_buf_pc[r_rptr]    : '0;
  assign instr_fault_o = w_valid & r_buf_fault[r_rptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect_valid_i) begin
      r_state <= S_RUN;
      r_pc    <= redirect_pc_i;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
        if (rom_illegal_i) begin
          r_state <= S_FAULT;
        end else begin
          r_pc <= r_pc + ADDR_WIDTH'(4);
        end
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage needs no reset: the head is masked by w_valid.
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_push) begin
      r_buf_pc[r_wptr]    <= r_pc;
      r_buf_instr[r_wptr] <= rom_illegal_i ? '0 : rom_data_i;
      r_buf_fault[r_wptr] <= rom_illegal_i;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [63:0] r_perf_fetched;
  logic [63:0] r_perf_stall;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push && !rom_illegal_i) begin
        r_perf_fetched <= r_perf_fetched + 64'd1;
      end
      if ((r_state == S_RUN) && w_full_after_pop && !redirect_valid_i) begin
        r_perf_stall <= r_perf_stall + 64'd1;
      end
    end
  end

  assign perf_fetched_o = r_perf_fetched;
  assign perf_stall_o   = r_perf_stall;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus queues expected {pc, instr, fault};
// a negedge monitor compares every accepted head entry.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [63:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        rom_illegal_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;
  logic        instr_fault_o;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetched_o;
  logic [63:0] perf_stall_o;
`endif

  instr_fetch_unit dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .rom_addr_o       (rom_addr_o),
    .rom_data_i       (rom_data_i),
    .rom_illegal_i    (rom_illegal_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_fault_o    (instr_fault_o)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched_o   (perf_fetched_o),
    .perf_stall_o     (perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // ROM image: word at address a is 0x13 + a*32, giving 0x13, 0x93, 0x113 at 0, 4, 8.
  assign rom_data_i    = 32'h13 + (rom_addr_o[31:0] << 5);
  assign rom_illegal_i = (rom_addr_o[1:0] != 2'b00);

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  entry_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_entry(input logic [63:0] pc, input logic [31:0] instr, input logic fault);
    entry_t e;
    e.pc = pc;
    e.instr = instr;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Holds ready high across n sampling points, so n head entries are accepted.
  task automatic accept(input int n);
    instr_ready_i = 1'b1;
    repeat (n) step();
    instr_ready_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && instr_valid_o === 1'b1 && instr_ready_i === 1'b1 && redirect_valid_i === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry actual pc=%h required none", instr_pc_o);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("head_pc", instr_pc_o, e.pc);
        chk("head_instr", 64'(instr_o), 64'(e.instr));
        chk("head_fault", 64'(instr_fault_o), 64'(e.fault));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni           = 1'b0;
    instr_ready_i    = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;

    // Reset values, then steady-state streaming with ready=1.
    step();
    step();
    @(negedge clk_i);
    chk("rst_valid", 64'(instr_valid_o), 64'd0);
    chk("rst_instr", 64'(instr_o), 64'd0);
    chk("rst_pc", instr_pc_o, 64'd0);
    chk("rst_fault", 64'(instr_fault_o), 64'd0);
    chk("rst_addr", rom_addr_o, 64'd0);
    rst_ni = 1'b1;
    expect_entry(64'h0, 32'h13, 1'b0);
    expect_entry(64'h4, 32'h93, 1'b0);
    expect_entry(64'h8, 32'h113, 1'b0);
    step();
    accept(3);

    // Backpressure: fresh reset with ready low fills the buffer and stalls the PC at 8.
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    repeat (5) step();
    @(negedge clk_i);
    chk("stall_addr", rom_addr_o, 64'h8);
    chk("stall_valid", 64'(instr_valid_o), 64'd1);
    chk("stall_head_pc", instr_pc_o, 64'h0);
    step();
    @(negedge clk_i);
    chk("stall_head_stable", 64'(instr_o), 64'h13);
    chk("stall_addr_held", rom_addr_o, 64'h8);
    expect_entry(64'h0, 32'h13, 1'b0);
    expect_entry(64'h4, 32'h93, 1'b0);
    expect_entry(64'h8, 32'h113, 1'b0);
    accept(3);

    // Redirect while full: head offered with ready=1 is dropped, old entries flushed.
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h40;
    instr_ready_i    = 1'b1;
    step();
    redirect_valid_i = 1'b0;
    instr_ready_i    = 1'b0;
    @(negedge clk_i);
    chk("redir_valid_low", 64'(instr_valid_o), 64'd0);
    chk("redir_addr", rom_addr_o, 64'h40);
    expect_entry(64'h40, 32'h813, 1'b0);
    expect_entry(64'h44, 32'h893, 1'b0);
    step();
    accept(2);

    // Unaligned target: single fault entry, fetch frozen until the next redirect.
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h42;
    step();
    redirect_valid_i = 1'b0;
    expect_entry(64'h42, 32'h0, 1'b1);
    repeat (4) step();
    @(negedge clk_i);
    chk("fault_addr", rom_addr_o, 64'h42);
    chk("fault_valid", 64'(instr_valid_o), 64'd1);
    chk("fault_flag", 64'(instr_fault_o), 64'd1);
    accept(1);
    @(negedge clk_i);
    chk("fault_no_more", 64'(instr_valid_o), 64'd0);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h44;
    step();
    redirect_valid_i = 1'b0;
    expect_entry(64'h44, 32'h893, 1'b0);
    expect_entry(64'h48, 32'h913, 1'b0);
    step();
    accept(2);

    // PC wrap at the top of the address space.
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid_i = 1'b0;
    expect_entry(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FF93, 1'b0);
    expect_entry(64'h0, 32'h13, 1'b0);
    step();
    accept(2);

    // Reset with two buffered entries discards them.
    step();
    @(negedge clk_i);
    chk("pre_rst_valid", 64'(instr_valid_o), 64'd1);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_valid", 64'(instr_valid_o), 64'd0);
    chk("mid_rst_addr", rom_addr_o, 64'h0);
`ifdef IFU_PERF_CNT_EN
    chk("mid_rst_perf_fetched", perf_fetched_o, 64'd0);
    chk("mid_rst_perf_stall", perf_stall_o, 64'd0);
`endif
    expect_entry(64'h0, 32'h13, 1'b0);
    step();
    accept(1);

    step();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
